// File: rtl/pio_arbiter.sv
// rtl/pio_arbiter.sv - two-master round-robin arbiter in front of a single PIO register slave
module pio_arbiter #(
    parameter int pADDRESS_BITS = 3,
    parameter int pDATA_BITS    = 32
) (
    input  logic                     iCLOCK,
    input  logic                     iRESET,
    input  logic [pADDRESS_BITS-1:0] iM0_ADDRESS,
    input  logic                     iM0_WRITE,
    input  logic                     iM0_READ,
    input  logic [pDATA_BITS-1:0]    iM0_WRITE_DATA,
    output logic                     oM0_WAIT_REQUEST,
    output logic [pDATA_BITS-1:0]    oM0_READ_DATA,
    output logic                     oM0_READ_DATA_VALID,
    input  logic [pADDRESS_BITS-1:0] iM1_ADDRESS,
    input  logic                     iM1_WRITE,
    input  logic                     iM1_READ,
    input  logic [pDATA_BITS-1:0]    iM1_WRITE_DATA,
    output logic                     oM1_WAIT_REQUEST,
    output logic [pDATA_BITS-1:0]    oM1_READ_DATA,
    output logic                     oM1_READ_DATA_VALID,
    output logic [pADDRESS_BITS-1:0] oS_ADDRESS,
    output logic                     oS_WRITE,
    output logic                     oS_READ,
    output logic [pDATA_BITS-1:0]    oS_WRITE_DATA,
    input  logic [pDATA_BITS-1:0]    iS_READ_DATA
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RWAIT = 2'd2
    } stateType;

    stateType state;
    stateType nextState;

    logic lastGrant;   // 0 = master 0 last accepted, 1 = master 1
    logic owner;       // master whose command is in flight
    logic req0;
    logic req1;
    logic accept0;
    logic accept1;
    logic grantWrite;
    logic grantRead;

    assign req0 = iM0_WRITE | iM0_READ;
    assign req1 = iM1_WRITE | iM1_READ;

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState        = state;
        accept0          = 1'b0;
        accept1          = 1'b0;
        oM0_WAIT_REQUEST = 1'b1;
        oM1_WAIT_REQUEST = 1'b1;
        case (state)
            IDLE: begin
                // Contention goes to the master not granted last; a lone requester always wins.
                if (!iRESET) begin
                    if (req0 && (!req1 || lastGrant)) begin
                        accept0 = 1'b1;
                    end else if (req1) begin
                        accept1 = 1'b1;
                    end
                end
                oM0_WAIT_REQUEST = ~accept0;
                oM1_WAIT_REQUEST = ~accept1;
                if (accept0 || accept1) begin
                    nextState = ISSUE;
                end
            end
            ISSUE:   nextState = oS_READ ? RWAIT : IDLE;
            RWAIT:   nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // A simultaneous write+read is carried out as a write only.
    assign grantWrite = accept1 ? iM1_WRITE : iM0_WRITE;
    assign grantRead  = accept1 ? (iM1_READ & ~iM1_WRITE) : (iM0_READ & ~iM0_WRITE);

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            oS_ADDRESS    <= '0;
            oS_WRITE_DATA <= '0;
            oS_WRITE      <= 1'b0;
            oS_READ       <= 1'b0;
            owner         <= 1'b0;
            lastGrant     <= 1'b1;
        end else if (accept0 || accept1) begin
            oS_ADDRESS    <= accept1 ? iM1_ADDRESS : iM0_ADDRESS;
            oS_WRITE_DATA <= accept1 ? iM1_WRITE_DATA : iM0_WRITE_DATA;
            oS_WRITE      <= grantWrite;
            oS_READ       <= grantRead;
            owner         <= accept1;
            lastGrant     <= accept1;
        end else begin
            oS_WRITE <= 1'b0;
            oS_READ  <= 1'b0;
        end
    end

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            oM0_READ_DATA       <= '0;
            oM1_READ_DATA       <= '0;
            oM0_READ_DATA_VALID <= 1'b0;
            oM1_READ_DATA_VALID <= 1'b0;
        end else begin
            oM0_READ_DATA_VALID <= (state == RWAIT) && !owner;
            oM1_READ_DATA_VALID <= (state == RWAIT) && owner;
            if (state == RWAIT && !owner) begin
                oM0_READ_DATA <= iS_READ_DATA;
            end
            if (state == RWAIT && owner) begin
                oM1_READ_DATA <= iS_READ_DATA;
            end
        end
    end

endmodule

// File: tb/tb_pio_arbiter.sv
// tb/tb_pio_arbiter.sv - directed-vector bench for pio_arbiter
module tb_pio_arbiter;

    logic        iCLOCK = 1'b0;
    logic        iRESET;
    logic [2:0]  iM0_ADDRESS;
    logic        iM0_WRITE;
    logic        iM0_READ;
    logic [31:0] iM0_WRITE_DATA;
    logic        oM0_WAIT_REQUEST;
    logic [31:0] oM0_READ_DATA;
    logic        oM0_READ_DATA_VALID;
    logic [2:0]  iM1_ADDRESS;
    logic        iM1_WRITE;
    logic        iM1_READ;
    logic [31:0] iM1_WRITE_DATA;
    logic        oM1_WAIT_REQUEST;
    logic [31:0] oM1_READ_DATA;
    logic        oM1_READ_DATA_VALID;
    logic [2:0]  oS_ADDRESS;
    logic        oS_WRITE;
    logic        oS_READ;
    logic [31:0] oS_WRITE_DATA;
    logic [31:0] iS_READ_DATA;

    int vectorCount = 0;
    int miscompareCount = 0;

    pio_arbiter #(.pADDRESS_BITS(3), .pDATA_BITS(32)) dut (
        .iCLOCK(iCLOCK), .iRESET(iRESET),
        .iM0_ADDRESS(iM0_ADDRESS), .iM0_WRITE(iM0_WRITE), .iM0_READ(iM0_READ),
        .iM0_WRITE_DATA(iM0_WRITE_DATA), .oM0_WAIT_REQUEST(oM0_WAIT_REQUEST),
        .oM0_READ_DATA(oM0_READ_DATA), .oM0_READ_DATA_VALID(oM0_READ_DATA_VALID),
        .iM1_ADDRESS(iM1_ADDRESS), .iM1_WRITE(iM1_WRITE), .iM1_READ(iM1_READ),
        .iM1_WRITE_DATA(iM1_WRITE_DATA), .oM1_WAIT_REQUEST(oM1_WAIT_REQUEST),
        .oM1_READ_DATA(oM1_READ_DATA), .oM1_READ_DATA_VALID(oM1_READ_DATA_VALID),
        .oS_ADDRESS(oS_ADDRESS), .oS_WRITE(oS_WRITE), .oS_READ(oS_READ),
        .oS_WRITE_DATA(oS_WRITE_DATA), .iS_READ_DATA(iS_READ_DATA)
    );

    always #5 iCLOCK = ~iCLOCK;

    task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            miscompareCount++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge iCLOCK);
        #1;
    endtask

    task automatic idleMasters();
        iM0_WRITE = 1'b0; iM0_READ = 1'b0; iM0_ADDRESS = '0; iM0_WRITE_DATA = '0;
        iM1_WRITE = 1'b0; iM1_READ = 1'b0; iM1_ADDRESS = '0; iM1_WRITE_DATA = '0;
    endtask

    initial begin
        iRESET = 1'b1;
        iS_READ_DATA = '0;
        idleMasters();
        tick();
        // Reset values, with a request present during reset
        iM0_WRITE = 1'b1;
        #1;
        checkValue("rst_wait0", 32'(oM0_WAIT_REQUEST), 32'd1);
        checkValue("rst_wait1", 32'(oM1_WAIT_REQUEST), 32'd1);
        checkValue("rst_swrite", 32'(oS_WRITE), 32'd0);
        checkValue("rst_sread", 32'(oS_READ), 32'd0);
        checkValue("rst_saddr", 32'(oS_ADDRESS), 32'd0);
        checkValue("rst_sdata", oS_WRITE_DATA, 32'd0);
        checkValue("rst_rdata0", oM0_READ_DATA, 32'd0);
        checkValue("rst_rdata1", oM1_READ_DATA, 32'd0);
        checkValue("rst_valid0", 32'(oM0_READ_DATA_VALID), 32'd0);
        checkValue("rst_valid1", 32'(oM1_READ_DATA_VALID), 32'd0);
        idleMasters();
        tick();
        iRESET = 1'b0;
        tick();
        checkValue("idle_swrite", 32'(oS_WRITE), 32'd0);

        // M0 write addr 1 data 0xFF, then back-to-back write in T+2
        iM0_WRITE = 1'b1; iM0_ADDRESS = 3'd1; iM0_WRITE_DATA = 32'h0000_00FF;
        #1;
        checkValue("w_wait0_T", 32'(oM0_WAIT_REQUEST), 32'd0);
        checkValue("w_wait1_T", 32'(oM1_WAIT_REQUEST), 32'd1);
        tick();
        iM0_ADDRESS = 3'd4; iM0_WRITE_DATA = 32'h0000_0022;
        #1;
        checkValue("w_swrite_T1", 32'(oS_WRITE), 32'd1);
        checkValue("w_sread_T1", 32'(oS_READ), 32'd0);
        checkValue("w_saddr_T1", 32'(oS_ADDRESS), 32'd1);
        checkValue("w_sdata_T1", oS_WRITE_DATA, 32'h0000_00FF);
        checkValue("w_wait0_T1", 32'(oM0_WAIT_REQUEST), 32'd1);
        tick();
        checkValue("w_wait0_T2", 32'(oM0_WAIT_REQUEST), 32'd0);
        checkValue("w_swrite_T2", 32'(oS_WRITE), 32'd0);
        checkValue("w_saddr_hold", 32'(oS_ADDRESS), 32'd1);
        tick();
        idleMasters();
        checkValue("w2_swrite", 32'(oS_WRITE), 32'd1);
        checkValue("w2_saddr", 32'(oS_ADDRESS), 32'd4);
        checkValue("w2_sdata", oS_WRITE_DATA, 32'h0000_0022);
        tick();
        checkValue("w2_done", 32'(oS_WRITE), 32'd0);

        // Both masters writing continuously from reset: M0, M1, M0, M1
        iRESET = 1'b1;
        tick();
        iRESET = 1'b0;
        iM0_WRITE = 1'b1; iM0_ADDRESS = 3'd5; iM0_WRITE_DATA = 32'h5;
        iM1_WRITE = 1'b1; iM1_ADDRESS = 3'd6; iM1_WRITE_DATA = 32'h6;
        #1;
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) begin
                checkValue($sformatf("rr_wait0_%0d", k), 32'(oM0_WAIT_REQUEST), ((k / 2) % 2 == 0) ? 32'd0 : 32'd1);
                checkValue($sformatf("rr_wait1_%0d", k), 32'(oM1_WAIT_REQUEST), ((k / 2) % 2 == 0) ? 32'd1 : 32'd0);
            end else begin
                checkValue($sformatf("rr_swrite_%0d", k), 32'(oS_WRITE), 32'd1);
                checkValue($sformatf("rr_saddr_%0d", k), 32'(oS_ADDRESS), ((k / 2) % 2 == 0) ? 32'd5 : 32'd6);
                checkValue($sformatf("rr_busy_%0d", k), 32'({oM0_WAIT_REQUEST, oM1_WAIT_REQUEST}), 32'd3);
            end
            tick();
        end
        idleMasters();
        tick();

        // M1 read addr 2, slave data valid in T+2, owner sees it in T+3
        iM1_READ = 1'b1; iM1_ADDRESS = 3'd2;
        #1;
        checkValue("r_wait1_T", 32'(oM1_WAIT_REQUEST), 32'd0);
        tick();
        idleMasters();
        iS_READ_DATA = 32'h1111_2222;
        checkValue("r_sread_T1", 32'(oS_READ), 32'd1);
        checkValue("r_swrite_T1", 32'(oS_WRITE), 32'd0);
        checkValue("r_saddr_T1", 32'(oS_ADDRESS), 32'd2);
        tick();
        iS_READ_DATA = 32'hA5A5_0001;
        checkValue("r_sread_T2", 32'(oS_READ), 32'd0);
        checkValue("r_valid1_T2", 32'(oM1_READ_DATA_VALID), 32'd0);
        tick();
        iS_READ_DATA = 32'h0;
        checkValue("r_rdata1_T3", oM1_READ_DATA, 32'hA5A5_0001);
        checkValue("r_valid1_T3", 32'(oM1_READ_DATA_VALID), 32'd1);
        checkValue("r_valid0_T3", 32'(oM0_READ_DATA_VALID), 32'd0);
        checkValue("r_rdata0_T3", oM0_READ_DATA, 32'd0);
        tick();
        checkValue("r_valid1_T4", 32'(oM1_READ_DATA_VALID), 32'd0);
        checkValue("r_rdata1_hold", oM1_READ_DATA, 32'hA5A5_0001);

        // M0 write+read together -> write only; M1 glitches a request while stalled
        iM0_WRITE = 1'b1; iM0_READ = 1'b1; iM0_ADDRESS = 3'd3; iM0_WRITE_DATA = 32'h10;
        #1;
        checkValue("wr_wait0", 32'(oM0_WAIT_REQUEST), 32'd0);
        tick();
        idleMasters();
        iM1_WRITE = 1'b1; iM1_ADDRESS = 3'd6; iM1_WRITE_DATA = 32'h77;
        #1;
        checkValue("wr_swrite", 32'(oS_WRITE), 32'd1);
        checkValue("wr_sread", 32'(oS_READ), 32'd0);
        checkValue("wr_saddr", 32'(oS_ADDRESS), 32'd3);
        checkValue("wr_sdata", oS_WRITE_DATA, 32'h10);
        checkValue("drop_wait1", 32'(oM1_WAIT_REQUEST), 32'd1);
        tick();
        idleMasters();
        checkValue("wr_sread_2", 32'(oS_READ), 32'd0);
        checkValue("wr_valid0_2", 32'(oM0_READ_DATA_VALID), 32'd0);
        tick();
        checkValue("wr_valid0_3", 32'(oM0_READ_DATA_VALID), 32'd0);
        checkValue("drop_swrite", 32'(oS_WRITE), 32'd0);
        checkValue("drop_saddr", 32'(oS_ADDRESS), 32'd3);
        tick();
        checkValue("wr_valid0_4", 32'(oM0_READ_DATA_VALID), 32'd0);
        checkValue("wr_rdata0", oM0_READ_DATA, 32'd0);

        // M0 read aborted by reset in RWAIT; M1 accepted right after release
        iM0_READ = 1'b1; iM0_ADDRESS = 3'd7;
        #1;
        checkValue("ab_wait0", 32'(oM0_WAIT_REQUEST), 32'd0);
        tick();
        idleMasters();
        checkValue("ab_sread", 32'(oS_READ), 32'd1);
        tick();
        iS_READ_DATA = 32'hDEAD_BEEF;
        iRESET = 1'b1;
        iM1_WRITE = 1'b1; iM1_ADDRESS = 3'd2; iM1_WRITE_DATA = 32'h33;
        #1;
        checkValue("ab_saddr_rst", 32'(oS_ADDRESS), 32'd0);
        checkValue("ab_rdata1_rst", oM1_READ_DATA, 32'd0);
        checkValue("ab_wait1_rst", 32'(oM1_WAIT_REQUEST), 32'd1);
        tick();
        checkValue("ab_valid0", 32'(oM0_READ_DATA_VALID), 32'd0);
        checkValue("ab_rdata0", oM0_READ_DATA, 32'd0);
        iRESET = 1'b0;
        #1;
        checkValue("ab_wait1_rel", 32'(oM1_WAIT_REQUEST), 32'd0);
        tick();
        idleMasters();
        checkValue("ab_swrite", 32'(oS_WRITE), 32'd1);
        checkValue("ab_sread2", 32'(oS_READ), 32'd0);
        checkValue("ab_saddr", 32'(oS_ADDRESS), 32'd2);
        checkValue("ab_sdata", oS_WRITE_DATA, 32'h33);
        checkValue("ab_valid0_2", 32'(oM0_READ_DATA_VALID), 32'd0);
        tick();
        checkValue("ab_valid0_3", 32'(oM0_READ_DATA_VALID), 32'd0);
        checkValue("ab_swrite_done", 32'(oS_WRITE), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
        $finish;
    end

endmodule
